inv_expand_key: RTL and testbench
=================================

INV_EXPAND_KEY -- requirements
Module: inv_expand_key

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  asynchronous, active-low reset: low clears state immediately, release is synchronous to clk.
REQ-003 start  input  1  request; sampled only in IDLE.
REQ-004 key_in  input  128  round key N, word order {w3,w2,w1,w0}: w0=[31:0], w3=[127:96], each word MSB-first.
REQ-005 rcon_index  input  8  round number N (1..10) of key_in.
REQ-006 key_out  output  128  round key N-1, same packing as key_in.
REQ-007 ready  output  1  one-cycle pulse: key_out just updated.
REQ-008 busy  output  1  high from the cycle after start acceptance until ready.

Function
REQ-009 Output math: k3=n3^n2, k2=n2^n1, k1=n1^n0, k0=n0^(SubWord(RotWord(k3))^rcon), where n=key_in words and k=key_out words.
REQ-010 RotWord: result[31:8]=x[23:0], result[7:0]=x[31:24].
REQ-011 Rcon: index 1..10 -> 01,02,04,08,10,20,40,80,1b,36 in bits [31:24], zeros elsewhere; any other index -> 32'h0.
REQ-012 A single codebase sbox instance (ports select, s_out, clk; one-cycle registered lookup) performs all four SubWord bytes serially, byte [7:0] first, [31:24] last.
REQ-013 FSM states: IDLE, SUB, FIN. IDLE->SUB when start=1, capturing key_in and rcon_index. SUB holds for 5 cycles (4 sbox issues, last result capture) via 3-bit counter. SUB->FIN. FIN->IDLE always.
REQ-014 In FIN, key_out registers the REQ-009 result and ready=1 for exactly one cycle; ready rises exactly 6 rising edges after the edge sampling start.
REQ-015 key_in and rcon_index are sampled only on the accepting edge; later changes have no effect on the result.
REQ-016 start is ignored while busy=1 or in FIN; no queuing.
REQ-017 start held high continuously yields back-to-back operations, one every 7 cycles.
REQ-018 key_out holds its value between ready pulses.
REQ-019 No latches: every combinational signal has a default on every path.

Reset
REQ-020 rst low, in any state: FSM->IDLE, counter=0, key_out=0, ready=0, busy=0, captured key/rcon/subword=0.
REQ-021 Reset mid-operation aborts the operation; no ready pulse is produced for it.
REQ-022 First start is honoured on the first rising edge after rst release.

Configuration
REQ-023 Macro INV_EXPAND_KEY_ERR_EN defined: add output err (1 bit); err is registered with ready, =1 when captured rcon_index is outside 1..10 (key_out still computed with rcon 0); err reset value 0; err clears on the next ready.
REQ-024 Macro undefined: no err port; out-of-range index silently uses rcon 0.

Verification
REQ-025 key_in=128'hb6630ca6e13f0cc8c9ee2589d014f9a8, rcon_index=10, start pulse -> ready after 6 edges; key_out=128'h575c006e28d1294119fadc21ac7766f3.
REQ-026 key_in=128'h2a6c760523a3393988542cb1a0fafe17, rcon_index=1 -> key_out=128'h09cf4f3cabf7158828aed2a62b7e1516.
REQ-027 Chain ten operations, feeding key_out back with rcon_index 10..1 from REQ-025 key -> final key_out=128'h09cf4f3cabf7158828aed2a62b7e1516.
REQ-028 Assert start again 2 cycles into the REQ-025 operation with a different key -> ignored; result equals REQ-025; busy stays high until ready.
REQ-029 Pull rst low 3 cycles after start -> key_out=0, busy=0, no ready pulse; a new REQ-026 request after release completes correctly.
REQ-030 With INV_EXPAND_KEY_ERR_EN, rcon_index=0 -> err=1 with ready; next request with rcon_index=10 -> err=0 and REQ-025 result.

Source files
------------

// File: rtl/inv_expand_key.sv
// inv_expand_key: derives AES-128 round key N-1 from round key N.
// The four SubWord bytes are looked up serially through one registered sbox.
// Optional build macro INV_EXPAND_KEY_ERR_EN adds an 'err' output flagging an
// out-of-range round number; without it such indices silently use rcon 0.

module sbox (
  input  logic       clk,
  input  logic [7:0] select,
  output logic [7:0] s_out
);

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ x;
      end else begin
        p = p;
      end
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // Forward AES sbox: inverse followed by the affine transform
  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  // One-cycle registered lookup
  always_ff @(posedge clk) begin
    s_out <= sbox_f(select);
  end

endmodule

module inv_expand_key (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon_index,
  output logic [127:0] key_out,
  output logic         ready,
  output logic         busy
`ifdef INV_EXPAND_KEY_ERR_EN
  ,
  output logic         err
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SUB  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [127:0] key_q, key_d;
  logic [7:0]   rcon_idx_q, rcon_idx_d;
  logic [31:0]  sub_q, sub_d;
  logic [127:0] key_out_q, key_out_d;
  logic         ready_q, ready_d;
  logic         busy_q, busy_d;

  logic [31:0]  k3_s;
  logic [31:0]  rot_s;
  logic [7:0]   sel_s;
  logic [7:0]   s_out_s;
  logic [127:0] result_s;

  // Round constant for round 1..10 in the top byte; anything else yields zero
  function automatic logic [31:0] rcon_f(input logic [7:0] idx);
    logic [7:0] rc;
    case (idx)
      8'd1:    rc = 8'h01;
      8'd2:    rc = 8'h02;
      8'd3:    rc = 8'h04;
      8'd4:    rc = 8'h08;
      8'd5:    rc = 8'h10;
      8'd6:    rc = 8'h20;
      8'd7:    rc = 8'h40;
      8'd8:    rc = 8'h80;
      8'd9:    rc = 8'h1b;
      8'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h000000};
  endfunction

  sbox u_sbox (
    .clk    (clk),
    .select (sel_s),
    .s_out  (s_out_s)
  );

  // Datapath: recovered k3, its rotation, the byte sent to the sbox and the final key
  always_comb begin
    k3_s  = key_q[127:96] ^ key_q[95:64];
    rot_s = {k3_s[23:0], k3_s[31:24]};
    case (cnt_q)
      3'd0:    sel_s = rot_s[7:0];
      3'd1:    sel_s = rot_s[15:8];
      3'd2:    sel_s = rot_s[23:16];
      3'd3:    sel_s = rot_s[31:24];
      default: sel_s = 8'h00;
    endcase
    result_s = {k3_s,
                key_q[95:64] ^ key_q[63:32],
                key_q[63:32] ^ key_q[31:0],
                key_q[31:0] ^ sub_q ^ rcon_f(rcon_idx_q)};
  end

  // Control FSM: capture on start, collect four sbox bytes, publish in FIN
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    key_d      = key_q;
    rcon_idx_d = rcon_idx_q;
    sub_d      = sub_q;
    key_out_d  = key_out_q;
    ready_d    = 1'b0;
    busy_d     = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SUB;
          cnt_d      = 3'd0;
          key_d      = key_in;
          rcon_idx_d = rcon_index;
          sub_d      = 32'h0;
          busy_d     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SUB: begin
        // sbox result for the byte issued last cycle is available now
        case (cnt_q)
          3'd1:    sub_d[7:0]   = s_out_s;
          3'd2:    sub_d[15:8]  = s_out_s;
          3'd3:    sub_d[23:16] = s_out_s;
          3'd4:    sub_d[31:24] = s_out_s;
          default: sub_d        = sub_q;
        endcase
        if (cnt_q == 3'd4) begin
          state_d = ST_FIN;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_FIN: begin
        state_d   = ST_IDLE;
        key_out_d = result_s;
        ready_d   = 1'b1;
        busy_d    = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      key_q      <= 128'h0;
      rcon_idx_q <= 8'h00;
      sub_q      <= 32'h0;
      key_out_q  <= 128'h0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_q      <= key_d;
      rcon_idx_q <= rcon_idx_d;
      sub_q      <= sub_d;
      key_out_q  <= key_out_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign key_out = key_out_q;
  assign ready   = ready_q;
  assign busy    = busy_q;

`ifdef INV_EXPAND_KEY_ERR_EN
  logic err_q, err_d;

  // Range flag refreshed together with each ready pulse, held otherwise
  always_comb begin
    if (state_q == ST_FIN) begin
      err_d = (rcon_idx_q == 8'd0) || (rcon_idx_q > 8'd10);
    end else begin
      err_d = err_q;
    end
  end

  // Error flag register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_inv_expand_key.sv
// Self-checking bench for inv_expand_key with a behavioural key-schedule model.
module tb_inv_expand_key;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic [7:0]   rcon_index;
  logic [127:0] key_out;
  logic         ready;
  logic         busy;
`ifdef INV_EXPAND_KEY_ERR_EN
  logic         err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sbox_tab [0:255];

  localparam logic [127:0] K25 = 128'hb6630ca6e13f0cc8c9ee2589d014f9a8;
  localparam logic [127:0] C25 = 128'h575c006e28d1294119fadc21ac7766f3;
  localparam logic [127:0] K26 = 128'h2a6c760523a3393988542cb1a0fafe17;
  localparam logic [127:0] C26 = 128'h09cf4f3cabf7158828aed2a62b7e1516;

  always #5 clk = ~clk;

  inv_expand_key dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_in     (key_in),
    .rcon_index (rcon_index),
    .key_out    (key_out),
    .ready      (ready),
    .busy       (busy)
`ifdef INV_EXPAND_KEY_ERR_EN
    ,
    .err        (err)
`endif
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Carry-less product reduced by the AES polynomial 0x11b
  function automatic int gmul(input int a, input int b);
    int p = 0;
    for (int i = 0; i < 8; i++) if (((b >> i) & 1) == 1) p = p ^ (a << i);
    for (int bit_i = 14; bit_i >= 8; bit_i--)
      if (((p >> bit_i) & 1) == 1) p = p ^ (32'h11b << (bit_i - 8));
    return p;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      logic [7:0] c;
      logic [7:0] s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(x, y) == 1) inv = 8'(y);
      c = 8'h63;
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
      sbox_tab[x] = s;
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] n, input logic [7:0] idx);
    logic [31:0] w [4];
    logic [31:0] k3, t, sub;
    int rc;
    for (int i = 0; i < 4; i++) w[i] = n[32*i +: 32];
    k3 = w[3] ^ w[2];
    t  = {k3[23:0], k3[31:24]};
    for (int i = 0; i < 4; i++) sub[8*i +: 8] = sbox_tab[t[8*i +: 8]];
    rc = 0;
    if (idx >= 8'd1 && idx <= 8'd10) begin
      rc = 1;
      for (int i = 1; i < int'(idx); i++) rc = gmul(rc, 2);
    end
    return {k3, w[2] ^ w[1], w[1] ^ w[0], w[0] ^ sub ^ {rc[7:0], 24'h0}};
  endfunction

  // Launch one request (caller is off the clock edge) and check its completion
  task automatic run_op(input logic [127:0] k, input logic [7:0] idx, input int restart_at,
                        output logic [127:0] res);
    logic [127:0] exp;
    int n;
    int busy_bad;
    bit got;
    exp = model(k, idx);
    key_in = k;
    rcon_index = idx;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    rcon_index = 8'($urandom);
    n = 0;
    got = 1'b0;
    busy_bad = (busy !== 1'b1) ? 1 : 0;
    while (n < 20 && !got) begin
      if (n == restart_at) begin
        start = 1'b1;
        key_in = ~k;
        rcon_index = 8'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (ready === 1'b1) got = 1'b1;
      else if (busy !== 1'b1) busy_bad++;
    end
    start = 1'b0;
    check_eq("latency", 128'(n), 128'd6);
    check_eq("key_out", key_out, exp);
    check_eq("busy_during_op", 128'(busy_bad), 128'd0);
    check_eq("busy_at_ready", 128'(busy), 128'd0);
`ifdef INV_EXPAND_KEY_ERR_EN
    check_eq("err", 128'(err), 128'((idx == 8'd0 || idx > 8'd10) ? 1 : 0));
`endif
    res = key_out;
    @(posedge clk); #1;
    check_eq("ready_one_cycle", 128'(ready), 128'd0);
    check_eq("key_out_hold", key_out, exp);
`ifdef INV_EXPAND_KEY_ERR_EN
    check_eq("err_hold", 128'(err), 128'((idx == 8'd0 || idx > 8'd10) ? 1 : 0));
`endif
  endtask

  initial begin
    logic [127:0] r;
    logic [127:0] k;
    logic [127:0] exp;
    int t [3];
    int nr;
    int cyc;
    int pulses;

    rst = 1'b0;
    start = 1'b0;
    key_in = 128'h0;
    rcon_index = 8'h00;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_key_out", key_out, 128'h0);
    check_eq("reset_ready", 128'(ready), 128'd0);
    check_eq("reset_busy", 128'(busy), 128'd0);

    // Release reset and request on the very next edge
    @(negedge clk);
    rst = 1'b1;
    run_op(K25, 8'd10, -1, r);
    check_eq("vec25", r, C25);
    run_op(K26, 8'd1, -1, r);
    check_eq("vec26", r, C26);

    // Ten-round inverse chain
    k = K25;
    for (int i = 10; i >= 1; i--) run_op(k, 8'(i), -1, k);
    check_eq("chain", k, C26);

    // Second start mid-operation is ignored
    run_op(K25, 8'd10, 2, r);
    check_eq("restart_ignored", r, C25);

    // Reset in the middle of an operation
    key_in = K25;
    rcon_index = 8'd10;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_eq("abort_key_out", key_out, 128'h0);
    check_eq("abort_busy", 128'(busy), 128'd0);
    check_eq("abort_ready", 128'(ready), 128'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ready === 1'b1) pulses++;
    end
    check_eq("abort_no_ready", 128'(pulses), 128'd0);
    run_op(K26, 8'd1, -1, r);
    check_eq("after_abort", r, C26);

    // start held high: one result every 7 cycles
    k = {$urandom, $urandom, $urandom, $urandom};
    rcon_index = 8'($urandom_range(1, 10));
    exp = model(k, rcon_index);
    key_in = k;
    start = 1'b1;
    nr = 0;
    cyc = 0;
    while (nr < 3 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (ready === 1'b1) begin
        t[nr] = cyc;
        nr++;
        check_eq("b2b_key_out", key_out, exp);
      end
    end
    start = 1'b0;
    check_eq("b2b_count", 128'(nr), 128'd3);
    check_eq("b2b_first", 128'(t[0]), 128'd7);
    check_eq("b2b_gap1", 128'(t[1] - t[0]), 128'd7);
    check_eq("b2b_gap2", 128'(t[2] - t[1]), 128'd7);
    repeat (8) @(posedge clk);
    #1;

    // Out-of-range index followed by a normal request
    run_op(K25, 8'd0, -1, r);
    run_op(K25, 8'd10, -1, r);
    check_eq("after_bad_idx", r, C25);

    // Randomized requests, including out-of-range indices
    for (int i = 0; i < 30; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      run_op(k, 8'($urandom_range(0, 15)), (i % 3 == 0) ? 1 + (i % 4) : -1, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
